// File: rtl/cv32e40p_obi_prefetch_ctrl.sv
// cv32e40p_obi_prefetch_ctrl: sequential OBI instruction prefetcher with credit-limited issue, response FIFO and branch discard
module cv32e40p_obi_prefetch_ctrl #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        busy_o,
  output logic        trans_valid_o,
  input  logic        trans_ready_i,
  output logic [31:0] trans_addr_o,
  input  logic        resp_valid_i,
  input  logic [31:0] resp_rdata_i,
  input  logic        resp_err_i,
  output logic        fetch_valid_o,
  output logic [31:0] fetch_rdata_o,
  output logic        fetch_err_o,
  input  logic        fetch_ready_i
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [31:0]   addr_q, addr_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d, discard_q, discard_d, fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [32:0]   mem_q [DEPTH];
  logic [CW:0]   used;
  logic          accept, drop, push, pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  // Every outstanding request owns a FIFO slot, so pushes can never overflow
  assign used          = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};
  assign trans_valid_o = req_i && !branch_i && (used < (CW+1)'(DEPTH));
  assign trans_addr_o  = addr_q;
  assign fetch_valid_o = (fifo_cnt_q != '0) && !branch_i;
  assign {fetch_err_o, fetch_rdata_o} = fifo_cnt_q != '0 ? mem_q[rd_q] : 33'd0;
  assign busy_o        = (out_cnt_q != '0) || (fifo_cnt_q != '0);
  assign accept        = trans_valid_o && trans_ready_i;
  assign drop          = resp_valid_i && (discard_q != '0);
  assign push          = resp_valid_i && (discard_q == '0) && !branch_i;
  assign pop           = fetch_valid_o && fetch_ready_i;

  always_comb begin
    addr_d     = branch_i ? {branch_addr_i[31:2], 2'b00} : accept ? addr_q + 32'd4 : addr_q;
    out_cnt_d  = out_cnt_q + CW'(accept) - CW'(resp_valid_i);
    discard_d  = branch_i ? out_cnt_q - CW'(resp_valid_i) : discard_q - CW'(drop);
    fifo_cnt_d = branch_i ? '0 : fifo_cnt_q + CW'(push) - CW'(pop);
    rd_d       = branch_i ? '0 : pop ? nxt(rd_q) : rd_q;
    wr_d       = branch_i ? '0 : push ? nxt(wr_q) : wr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= '0;
      out_cnt_q  <= '0;
      discard_q  <= '0;
      fifo_cnt_q <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
    end else begin
      addr_q     <= addr_d;
      out_cnt_q  <= out_cnt_d;
      discard_q  <= discard_d;
      fifo_cnt_q <= fifo_cnt_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {resp_err_i, resp_rdata_i};
  end
endmodule

// File: tb/tb_cv32e40p_obi_prefetch_ctrl.sv
// tb_cv32e40p_obi_prefetch_ctrl: directed and random stimulus against a queue-based reference of the prefetcher
module tb_cv32e40p_obi_prefetch_ctrl;
  localparam int DEPTH = 2;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_i = 1'b0, branch_i = 1'b0, trans_ready_i = 1'b0;
  logic        resp_valid_i = 1'b0, resp_err_i = 1'b0, fetch_ready_i = 1'b0;
  logic [31:0] branch_addr_i = '0, resp_rdata_i = '0;
  logic        busy_o, trans_valid_o, fetch_valid_o, fetch_err_o;
  logic [31:0] trans_addr_o, fetch_rdata_o;
  int checks = 0, errors = 0;

  typedef struct { logic [31:0] a; bit stale; } oe_t;
  typedef struct { logic e; logic [31:0] d; } fe_t;
  oe_t         out_q[$];
  fe_t         fq[$];
  logic [31:0] m_addr = '0;

  cv32e40p_obi_prefetch_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .busy_o(busy_o), .trans_valid_o(trans_valid_o), .trans_ready_i(trans_ready_i), .trans_addr_o(trans_addr_o),
    .resp_valid_i(resp_valid_i), .resp_rdata_i(resp_rdata_i), .resp_err_i(resp_err_i),
    .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o), .fetch_err_o(fetch_err_o),
    .fetch_ready_i(fetch_ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // One bus cycle: the bench acts as the OBI adapter, answering requests in order with rdata = address
  task automatic step(input bit rq, input bit br, input logic [31:0] ba, input bit tr, input bit fr,
                      input bit rv, input bit er);
    bit  rv_e, etv, efv;
    oe_t h;
    @(negedge clk);
    rv_e          = rv && out_q.size() != 0;
    req_i         = rq;
    branch_i      = br;
    branch_addr_i = ba;
    trans_ready_i = tr;
    fetch_ready_i = fr;
    resp_valid_i  = rv_e;
    resp_rdata_i  = rv_e ? out_q[0].a : 32'd0;
    resp_err_i    = rv_e && er;
    #1;
    etv = rq && !br && (out_q.size() + fq.size() < DEPTH);
    efv = fq.size() != 0 && !br;
    chk("trans_valid", 32'(trans_valid_o), 32'(etv));
    chk("trans_addr", trans_addr_o, m_addr);
    chk("fetch_valid", 32'(fetch_valid_o), 32'(efv));
    chk("busy", 32'(busy_o), 32'(out_q.size() != 0 || fq.size() != 0));
    if (efv) begin
      chk("fetch_rdata", fetch_rdata_o, fq[0].d);
      chk("fetch_err", 32'(fetch_err_o), 32'(fq[0].e));
    end
    @(posedge clk);
    if (efv && fr) void'(fq.pop_front());
    if (rv_e) begin
      h = out_q.pop_front();
      if (!h.stale && !br) fq.push_back('{e: er, d: h.a});
    end
    if (br) begin
      fq.delete();
      foreach (out_q[i]) out_q[i].stale = 1'b1;
      m_addr = {ba[31:2], 2'b00};
    end else if (etv && tr) begin
      out_q.push_back('{a: m_addr, stale: 1'b0});
      m_addr = m_addr + 32'd4;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_tv"}, 32'(trans_valid_o), 32'd0);
    chk({tag, "_ta"}, trans_addr_o, 32'd0);
    chk({tag, "_fv"}, 32'(fetch_valid_o), 32'd0);
    chk({tag, "_fd"}, fetch_rdata_o, 32'd0);
    chk({tag, "_fe"}, 32'(fetch_err_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    chk_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // Sequential stream from 0x1000
    step(0, 1, 32'h0000_1000, 1, 1, 0, 0);
    repeat (16) step(1, 0, 0, 1, 1, 1, 0);
    // Backpressure, then a single pop frees one credit
    repeat (6) step(1, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 1, 1, 0);
    repeat (3) step(1, 0, 0, 1, 0, 1, 0);
    // Branch with two requests in flight
    step(0, 1, 32'h0000_0100, 1, 1, 0, 0);
    repeat (3) step(1, 0, 0, 1, 1, 0, 0);
    step(0, 1, 32'h0000_0200, 1, 1, 0, 0);
    repeat (8) step(1, 0, 0, 1, 1, 1, 0);
    // Branch coinciding with a response and a non-empty FIFO
    step(0, 1, 32'h0000_0400, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(1, 0, 0, 1, 0, 1, 0);
    step(1, 0, 0, 1, 0, 0, 0);
    step(0, 1, 32'h0000_0800, 1, 0, 1, 0);
    repeat (8) step(1, 0, 0, 1, 1, 1, 0);
    // Wrap past 0xFFFFFFFC with an errored first response
    step(0, 1, 32'hFFFF_FFFF, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1, 1, 1);
    repeat (8) step(1, 0, 0, 1, 1, 1, 0);
    // Random traffic
    for (int i = 0; i < 3000; i++)
      step($urandom % 8 != 0, $urandom % 20 == 0, $urandom, $urandom % 4 != 0,
           $urandom % 3 != 0, $urandom % 3 != 0, $urandom % 8 == 0);
    // Asynchronous reset mid-stream with the FIFO filling up
    repeat (4) step(1, 0, 0, 1, 0, 1, 0);
    @(negedge clk);
    req_i = 1'b0; branch_i = 1'b0; resp_valid_i = 1'b0; resp_err_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    out_q.delete();
    fq.delete();
    m_addr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 32'h0000_3000, 1, 1, 0, 0);
    repeat (10) step(1, 0, 0, 1, 1, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
